// File: rtl/ballplayer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ballplayer_pkg
// Description : Shared types and default constants for the ball array engine
// Revision    : 1.0 - initial release
// ============================================================================
package ballplayer_pkg;

    // Per-ball motion state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_RISE = 2'd2,
        ST_DEAD = 2'd3
    } ball_state_e;

    localparam int Y_W_DEF     = 9;    // default coordinate width
    localparam int VMAX_DEF    = 31;   // default velocity saturation value
    localparam int Y_FLOOR_DEF = 310;  // default miss line

endpackage
`default_nettype wire

// File: rtl/ball_lane.sv
`default_nettype none
// ============================================================================
// Module      : ball_lane
// Description : One ball: IDLE/FALL/RISE/DEAD state machine with tick-driven
//               gravity, paddle bounce and floor miss.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_lane
    import ballplayer_pkg::*;
#(
    parameter int Y_W     = Y_W_DEF,
    parameter int GRAVITY = 1,
    parameter int VMAX    = VMAX_DEF,
    parameter int Y_FLOOR = Y_FLOOR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_i,
    input  logic           start_i,
    input  logic [Y_W-1:0] home_i,
    input  logic [Y_W-1:0] handline_i,
    input  logic [7:0]     hand_velocity_i,
    input  logic [1:0]     k_i,
    output logic [Y_W-1:0] y_o,
    output logic           idle_o,
    output logic           dead_o,
    output logic           active_o,
    output logic           beep_o,
    output logic           hit_o
);

    // Working width leaves headroom for the elasticity product so nothing wraps
    localparam int AW = Y_W + 4;
    typedef logic [AW-1:0] aw_t;

    localparam aw_t             G_A     = aw_t'(GRAVITY);
    localparam aw_t             VMAX_A  = aw_t'(VMAX);
    localparam aw_t             FLOOR_A = aw_t'(Y_FLOOR);
    localparam logic [Y_W-1:0]  FLOOR_Y = Y_W'(Y_FLOOR);

    ball_state_e    state_q;
    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] v_q;
    logic           active_q;
    logic           beep_q;

    aw_t  y_d, v_d, hl_d, vn_d, fall_sum_d, rebound_d, hit_y_d, rise_y_d, rise_v_d;
    logic hit_d, miss_d, rise_stop_d;

    // Candidate next position/velocity for the falling and rising cases
    always_comb begin
        y_d        = aw_t'(y_q);
        v_d        = aw_t'(v_q);
        hl_d       = aw_t'(handline_i);
        vn_d       = (v_d + G_A > VMAX_A) ? VMAX_A : v_d + G_A;
        fall_sum_d = y_d + vn_d;
        hit_d      = (y_d < hl_d) && (fall_sum_d >= hl_d);
        miss_d     = (fall_sum_d >= FLOOR_A);
        hit_y_d    = (hl_d > FLOOR_A) ? FLOOR_A : hl_d;
        rebound_d  = ((aw_t'(3'd4 - {1'b0, k_i}) * vn_d) >> 2)
                   + aw_t'(hand_velocity_i >> 2);
        if (rebound_d > VMAX_A) begin
            rebound_d = VMAX_A;
        end
        rise_y_d    = (v_d >= y_d) ? '0 : y_d - v_d;
        rise_v_d    = (v_d > G_A) ? v_d - G_A : '0;
        rise_stop_d = (rise_v_d <= G_A) || (rise_y_d == '0);
    end

    // Ball state machine; a start request pre-empts any coincident tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            y_q      <= '0;
            v_q      <= '0;
            active_q <= 1'b0;
            beep_q   <= 1'b0;
        end else begin
            beep_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    y_q <= home_i;
                    v_q <= '0;
                    if (start_i) begin
                        state_q  <= ST_FALL;
                        active_q <= 1'b1;
                    end
                end
                ST_FALL: begin
                    if (tick_i) begin
                        if (hit_d) begin
                            y_q     <= hit_y_d[Y_W-1:0];
                            v_q     <= rebound_d[Y_W-1:0];
                            state_q <= ST_RISE;
                            beep_q  <= 1'b1;
                        end else if (miss_d) begin
                            y_q      <= FLOOR_Y;
                            v_q      <= '0;
                            state_q  <= ST_DEAD;
                            active_q <= 1'b0;
                        end else begin
                            y_q <= fall_sum_d[Y_W-1:0];
                            v_q <= vn_d[Y_W-1:0];
                        end
                    end
                end
                ST_RISE: begin
                    if (tick_i) begin
                        y_q <= rise_y_d[Y_W-1:0];
                        if (rise_stop_d) begin
                            v_q     <= '0;
                            state_q <= ST_FALL;
                        end else begin
                            v_q <= rise_v_d[Y_W-1:0];
                        end
                    end
                end
                ST_DEAD: begin
                    y_q      <= FLOOR_Y;
                    active_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign y_o      = y_q;
    assign idle_o   = (state_q == ST_IDLE);
    assign dead_o   = (state_q == ST_DEAD);
    assign active_o = active_q;
    assign beep_o   = beep_q;
    // Same-edge hit indication so the shared counter moves with beep
    assign hit_o    = tick_i && (state_q == ST_FALL) && hit_d;

endmodule
`default_nettype wire

// File: rtl/ball_array_engine.sv
`default_nettype none
// ============================================================================
// Module      : ball_array_engine
// Description : N independent bouncing balls sharing a physics tick, a
//               synchronised release button, a hit counter and game-over flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_array_engine
    import ballplayer_pkg::*;
#(
    parameter int N_BALLS  = 2,
    parameter int Y_W      = Y_W_DEF,
    parameter int TICK_DIV = 200000,
    parameter int GRAVITY  = 1,
    parameter int VMAX     = VMAX_DEF,
    parameter int Y_FLOOR  = Y_FLOOR_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [Y_W-1:0]         home,
    input  logic [Y_W-1:0]         handline,
    input  logic [7:0]             hand_velocity,
    input  logic [1:0]             k,
    input  logic                   release_i,
    input  logic                   mode,
    output logic [N_BALLS*Y_W-1:0] pic_y,
    output logic [N_BALLS-1:0]     active,
    output logic [N_BALLS-1:0]     beep,
    output logic [7:0]             hit_count,
    output logic                   over_flag,
    output logic                   tick
);

    localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]      cnt_q;
    logic               tick_q;
    logic [2:0]         sync_q;
    logic [7:0]         hit_count_q;
    logic               over_q;

    logic               rel_evt_d;
    logic [N_BALLS-1:0] grant_d;
    logic [N_BALLS-1:0] idle_d;
    logic [N_BALLS-1:0] dead_d;
    logic [N_BALLS-1:0] hit_d;
    logic [2:0]         n_hits_d;
    logic [8:0]         hit_sum_d;

    // Physics tick divider: one-cycle strobe each time the counter wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == CNT_LAST);
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], release_i};
        end
    end

    assign rel_evt_d = sync_q[1] & ~sync_q[2];

    // Release arbiter: all idle balls in mode 1, lowest idle ball otherwise
    always_comb begin
        grant_d = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            if (rel_evt_d && idle_d[i] && (mode || (grant_d == '0))) begin
                grant_d[i] = 1'b1;
            end
        end
    end

    // Number of paddle hits landing on this edge, and the saturated total
    always_comb begin
        n_hits_d = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            n_hits_d = n_hits_d + {2'b00, hit_d[i]};
        end
        hit_sum_d = {1'b0, hit_count_q} + {6'b0, n_hits_d};
    end

    // Hit counter and sticky game-over flag
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q <= '0;
            over_q      <= 1'b0;
        end else begin
            hit_count_q <= (hit_sum_d > 9'd255) ? 8'd255 : hit_sum_d[7:0];
            over_q      <= over_q | (&dead_d);
        end
    end

    generate
        for (genvar g = 0; g < N_BALLS; g++) begin : g_lane
            ball_lane #(
                .Y_W     (Y_W),
                .GRAVITY (GRAVITY),
                .VMAX    (VMAX),
                .Y_FLOOR (Y_FLOOR)
            ) u_lane (
                .clk             (clk),
                .rst             (rst),
                .tick_i          (tick_q),
                .start_i         (grant_d[g]),
                .home_i          (home),
                .handline_i      (handline),
                .hand_velocity_i (hand_velocity),
                .k_i             (k),
                .y_o             (pic_y[g*Y_W +: Y_W]),
                .idle_o          (idle_d[g]),
                .dead_o          (dead_d[g]),
                .active_o        (active[g]),
                .beep_o          (beep[g]),
                .hit_o           (hit_d[g])
            );
        end
    endgenerate

    assign tick      = tick_q;
    assign hit_count = hit_count_q;
    assign over_flag = over_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_array_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_array_engine
// Description : Randomised and directed bench with a cycle-level reference
//               model of the ball rules for a two-ball, four-cycle-tick build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_array_engine;

    localparam int NB = 2;
    localparam int YW = 9;
    localparam int TD = 4;
    localparam int G  = 1;
    localparam int VM = 31;
    localparam int FL = 310;

    localparam int M_IDLE = 0;
    localparam int M_FALL = 1;
    localparam int M_RISE = 2;
    localparam int M_DEAD = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [YW-1:0]    home;
    logic [YW-1:0]    handline;
    logic [7:0]       hv;
    logic [1:0]       k;
    logic             release_r;
    logic             mode;
    logic [NB*YW-1:0] pic_y;
    logic [NB-1:0]    active;
    logic [NB-1:0]    beep;
    logic [7:0]       hit_count;
    logic             over_flag;
    logic             tick;
    logic [31:0]      obs;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    int m_cnt, m_tick, m_hits, m_over;
    int m_lvl[3];
    int m_st[NB];
    int m_y[NB];
    int m_v[NB];
    int m_beep[NB];

    always #5 clk = ~clk;

    assign obs = {pic_y, active, beep, hit_count, over_flag, tick};

    ball_array_engine #(
        .N_BALLS  (NB),
        .Y_W      (YW),
        .TICK_DIV (TD),
        .GRAVITY  (G),
        .VMAX     (VM),
        .Y_FLOOR  (FL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .home          (home),
        .handline      (handline),
        .hand_velocity (hv),
        .k             (k),
        .release_i     (release_r),
        .mode          (mode),
        .pic_y         (pic_y),
        .active        (active),
        .beep          (beep),
        .hit_count     (hit_count),
        .over_flag     (over_flag),
        .tick          (tick)
    );

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Advance the model by one clock edge using the inputs present before it
    task automatic model_edge();
        int tk, ev, nh, all_dead, found, vn;
        int gr[NB];
        if (rst) begin
            m_cnt = 0; m_tick = 0; m_hits = 0; m_over = 0;
            for (int j = 0; j < 3; j++) m_lvl[j] = 0;
            for (int b = 0; b < NB; b++) begin
                m_st[b] = M_IDLE; m_y[b] = 0; m_v[b] = 0; m_beep[b] = 0;
            end
            return;
        end
        tk = m_tick;
        ev = (m_lvl[1] == 1 && m_lvl[2] == 0) ? 1 : 0;
        all_dead = 1; found = 0; nh = 0;
        for (int b = 0; b < NB; b++) if (m_st[b] != M_DEAD) all_dead = 0;
        for (int b = 0; b < NB; b++) begin
            gr[b] = 0;
            if (ev == 1 && m_st[b] == M_IDLE && (mode == 1'b1 || found == 0)) begin
                gr[b] = 1; found = 1;
            end
        end
        for (int b = 0; b < NB; b++) begin
            m_beep[b] = 0;
            if (m_st[b] == M_IDLE) begin
                m_y[b] = int'(home); m_v[b] = 0;
                if (gr[b] == 1) m_st[b] = M_FALL;
            end else if (m_st[b] == M_FALL && tk == 1) begin
                vn = imin(m_v[b] + G, VM);
                if (m_y[b] < int'(handline) && m_y[b] + vn >= int'(handline)) begin
                    m_y[b] = imin(int'(handline), FL);
                    m_v[b] = imin(((4 - int'(k)) * vn) / 4 + int'(hv) / 4, VM);
                    m_st[b] = M_RISE; m_beep[b] = 1; nh++;
                end else if (m_y[b] + vn >= FL) begin
                    m_y[b] = FL; m_v[b] = 0; m_st[b] = M_DEAD;
                end else begin
                    m_y[b] = m_y[b] + vn; m_v[b] = vn;
                end
            end else if (m_st[b] == M_RISE && tk == 1) begin
                m_y[b] = imax(m_y[b] - m_v[b], 0);
                m_v[b] = imax(m_v[b] - G, 0);
                if (m_v[b] <= G || m_y[b] == 0) begin
                    m_v[b] = 0; m_st[b] = M_FALL;
                end
            end
        end
        m_hits = imin(m_hits + nh, 255);
        if (all_dead == 1) m_over = 1;
        m_tick = (m_cnt == TD - 1) ? 1 : 0;
        m_cnt  = (m_cnt + 1) % TD;
        m_lvl[2] = m_lvl[1]; m_lvl[1] = m_lvl[0]; m_lvl[0] = int'(release_r);
    endtask

    function automatic logic [31:0] exp_vec();
        logic a0, a1;
        a0 = (m_st[0] == M_FALL || m_st[0] == M_RISE);
        a1 = (m_st[1] == M_FALL || m_st[1] == M_RISE);
        return {9'(m_y[1]), 9'(m_y[0]), a1, a0, m_beep[1][0], m_beep[0][0],
                8'(m_hits), m_over[0], m_tick[0]};
    endfunction

    // One clock: model follows the edge, outputs are then read at the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (obs !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", cyc, obs);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_free_fall();
        int got[3];
        int nchg;
        logic [8:0] prev;
        home = 9'd10; handline = 9'd300; k = 2'd0; hv = 8'd0; mode = 1'b0; release_r = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 3; c++) step();
        for (int j = 0; j < 3; j++) got[j] = 0;
        nchg = 0; prev = pic_y[8:0];
        release_r = 1'b1;
        for (int c = 0; c < 40 && nchg < 3; c++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL free_fall_model cycle %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (pic_y[8:0] !== prev) begin
                got[nchg] = int'(pic_y[8:0]); nchg++; prev = pic_y[8:0];
            end
        end
        n_tests++;
        if (got[0] != 11 || got[1] != 13 || got[2] != 16) begin
            n_fail++;
            $display("FAIL free_fall_path: got %0d,%0d,%0d expected 11,13,16", got[0], got[1], got[2]);
        end
        n_tests++;
        if (pic_y[17:9] !== 9'd10 || active[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL free_fall_ball1_idle: got y=%0d act=%b expected y=10 act=0", pic_y[17:9], active[1]);
        end
        release_r = 1'b0;
    endtask

    // Drop ball 0 from home and check the first hit position/count and the
    // first position after the rebound
    task automatic run_bounce(input string name, input int hit_y, input int after_y);
        int seen, done;
        logic [8:0] prev;
        seen = 0; done = 0; prev = '0;
        release_r = 1'b1;
        for (int c = 0; c < 200 && done == 0; c++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_model cycle %0d: got %h expected %h", name, cyc, obs, exp_vec());
            end
            if (seen == 1 && pic_y[8:0] !== prev) begin
                done = 1;
                n_tests++;
                if (int'(pic_y[8:0]) != after_y) begin
                    n_fail++;
                    $display("FAIL %s_rebound_y: got %0d expected %0d", name, pic_y[8:0], after_y);
                end
            end
            if (seen == 0 && beep[0] === 1'b1) begin
                seen = 1; prev = pic_y[8:0];
                n_tests++;
                if (int'(pic_y[8:0]) != hit_y || hit_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL %s_hit: got y=%0d count=%0d expected y=%0d count=1", name, pic_y[8:0], hit_count, hit_y);
                end
            end
        end
        n_tests++;
        if (done == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got seen=%0d expected hit and rebound", name, seen);
        end
        release_r = 1'b0;
    endtask

    task automatic test_bounce();
        home = 9'd10; handline = 9'd16; k = 2'd0; hv = 8'd0; mode = 1'b0; release_r = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        run_bounce("bounce", 16, 13);
    endtask

    task automatic test_elasticity();
        home = 9'd0; handline = 9'd200; k = 2'd2; hv = 8'd8; mode = 1'b0; release_r = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        run_bounce("elasticity", 200, 188);
    endtask

    task automatic test_miss_over();
        int first_act;
        home = 9'd10; handline = 9'd5; k = 2'd0; hv = 8'd0; mode = 1'b1; release_r = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step(); step();
        first_act = 0;
        release_r = 1'b1;
        for (int c = 0; c < 250 && over_flag !== 1'b1; c++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL miss_model cycle %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (first_act == 0 && active !== 2'b00) begin
                first_act = 1;
                n_tests++;
                if (active !== 2'b11) begin
                    n_fail++;
                    $display("FAIL mode1_both_active: got %b expected 11", active);
                end
            end
        end
        n_tests++;
        if (pic_y !== {9'd310, 9'd310} || over_flag !== 1'b1 || active !== 2'b00) begin
            n_fail++;
            $display("FAIL miss_final: got y1=%0d y0=%0d over=%b act=%b expected 310 310 1 00",
                     pic_y[17:9], pic_y[8:0], over_flag, active);
        end
        // Further presses with no idle ball change nothing
        release_r = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) release_r = 1'b1;
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL dead_press cycle %0d: got %h expected %h", cyc, obs, exp_vec());
            end
        end
        release_r = 1'b0;
    endtask

    // Sweep the press over every tick phase so one press lands on a tick
    task automatic test_press_on_tick();
        home = 9'd50; handline = 9'd300; k = 2'd0; hv = 8'd0; mode = 1'b0;
        for (int p = 0; p < TD; p++) begin
            release_r = 1'b0;
            rst = 1'b1; step(); rst = 1'b0;
            for (int c = 0; c < p; c++) step();
            release_r = 1'b1;
            for (int c = 0; c < 24; c++) begin
                step();
                n_tests++;
                if (obs !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL press_phase%0d cycle %0d: got %h expected %h", p, cyc, obs, exp_vec());
                end
            end
        end
        release_r = 1'b0;
    endtask

    task automatic test_hit_saturation();
        home = 9'd100; handline = 9'd103; k = 2'd0; hv = 8'd0; mode = 1'b1; release_r = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        release_r = 1'b1;
        for (int c = 0; c < 1900; c++) begin
            step();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL saturation_model cycle %0d: got %h expected %h", cyc, obs, exp_vec());
            end
        end
        n_tests++;
        if (hit_count !== 8'd255) begin
            n_fail++;
            $display("FAIL hit_count_saturate: got %0d expected 255", hit_count);
        end
        release_r = 1'b0;
    endtask

    task automatic test_random();
        logic was_rst;
        rst = 1'b1; step(); rst = 1'b0;
        home = 9'($urandom_range(0, FL)); handline = 9'($urandom_range(0, FL));
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) release_r = ~release_r;
            if ($urandom_range(0, 40) == 0) home = 9'($urandom_range(0, FL));
            if ($urandom_range(0, 40) == 0) handline = 9'($urandom_range(0, FL));
            if ($urandom_range(0, 30) == 0) k = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) hv = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 20) == 0) mode = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            was_rst = rst;
            step();
            rst = 1'b0;
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (was_rst) begin
                n_tests++;
                if (obs !== 32'd0) begin
                    n_fail++;
                    $display("FAIL midflight_reset cycle %0d: got %h expected 0", cyc, obs);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; home = '0; handline = '0; hv = '0; k = '0; release_r = 1'b0; mode = 1'b0;
        @(negedge clk);
        test_reset();
        test_free_fall();
        test_bounce();
        test_elasticity();
        test_miss_over();
        test_press_on_tick();
        test_hit_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
